// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped table of 2-bit saturating counters plus a tagged branch
//   target buffer. Fetch asks for a prediction and receives a registered
//   taken/target answer one cycle later; execute returns resolved outcomes
//   that train the counters and BTB and bump the performance counters.
//
// Ports
//   clk            in   clock, all state on rising edge
//   rst_n          in   asynchronous active-low reset
//   pred_req       in   prediction request for pred_pc
//   pred_pc        in   fetch PC (bits [1:0] ignored)
//   pred_valid     out  prediction valid (cycle after pred_req)
//   pred_taken     out  predicted taken
//   pred_target    out  predicted next PC
//   upd_valid      in   resolved branch presented this cycle
//   upd_pc         in   PC of resolved branch
//   upd_br_en      in   resolved outcome
//   upd_target     in   resolved taken target
//   upd_pred_taken in   prediction originally used for this branch
//   flush          in   invalidate all BTB entries (synchronous)
//   br_count       out  resolved branches, saturating
//   mispred_count  out  mispredictions, saturating
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int         IDX_WIDTH = 6,
    parameter int         TAG_WIDTH = 8,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_br_en,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int DEPTH = 2 ** IDX_WIDTH;

    logic [1:0]           cnt_reg        [DEPTH];
    logic [DEPTH-1:0]     btb_valid_reg;
    logic [TAG_WIDTH-1:0] btb_tag_reg    [DEPTH];
    logic [31:0]          btb_target_reg [DEPTH];

    logic        pred_valid_reg;
    logic        pred_taken_reg;
    logic [31:0] pred_target_reg;
    logic [31:0] br_count_reg;
    logic [31:0] mispred_count_reg;

    logic [IDX_WIDTH-1:0] pred_idx;
    logic [TAG_WIDTH-1:0] pred_tag;
    logic [IDX_WIDTH-1:0] upd_idx;
    logic [TAG_WIDTH-1:0] upd_tag;

    assign pred_idx = pred_pc[IDX_WIDTH+1:2];
    assign pred_tag = pred_pc[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2];
    assign upd_idx  = upd_pc[IDX_WIDTH+1:2];
    assign upd_tag  = upd_pc[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2];

    // Prediction is computed from the table as it stands before this edge's
    // update, so a same-cycle update to the same entry is not bypassed.
    logic        pred_hit;
    logic        pred_taken_next;
    logic [31:0] pred_target_next;

    always_comb begin
        pred_hit         = btb_valid_reg[pred_idx] && (btb_tag_reg[pred_idx] == pred_tag);
        pred_taken_next  = pred_hit && cnt_reg[pred_idx][1];
        pred_target_next = pred_taken_next ? btb_target_reg[pred_idx] : (pred_pc + 32'd4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_reg  <= 1'b0;
            pred_taken_reg  <= 1'b0;
            pred_target_reg <= 32'd0;
        end else begin
            pred_valid_reg <= pred_req;
            if (pred_req) begin
                pred_taken_reg  <= pred_taken_next;
                pred_target_reg <= pred_target_next;
            end
        end
    end

    // Saturating 2-bit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_reg[i] <= CNT_INIT;
            end
        end else if (upd_valid) begin
            if (upd_br_en) begin
                if (cnt_reg[upd_idx] != 2'b11) begin
                    cnt_reg[upd_idx] <= cnt_reg[upd_idx] + 2'd1;
                end
            end else begin
                if (cnt_reg[upd_idx] != 2'b00) begin
                    cnt_reg[upd_idx] <= cnt_reg[upd_idx] - 2'd1;
                end
            end
        end
    end

    // Flush clears valid bits only and beats a same-cycle BTB write.
    logic btb_write;
    assign btb_write = upd_valid && upd_br_en && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_reg <= '0;
        end else if (flush) begin
            btb_valid_reg <= '0;
        end else if (btb_write) begin
            btb_valid_reg[upd_idx] <= 1'b1;
        end
    end

    // Tags and targets need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (btb_write) begin
            btb_tag_reg[upd_idx]    <= upd_tag;
            btb_target_reg[upd_idx] <= upd_target;
        end
    end

    // Performance counters, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_reg      <= 32'd0;
            mispred_count_reg <= 32'd0;
        end else if (upd_valid) begin
            if (br_count_reg != 32'hFFFF_FFFF) begin
                br_count_reg <= br_count_reg + 32'd1;
            end
            if ((upd_br_en != upd_pred_taken) && (mispred_count_reg != 32'hFFFF_FFFF)) begin
                mispred_count_reg <= mispred_count_reg + 32'd1;
            end
        end
    end

    assign pred_valid    = pred_valid_reg;
    assign pred_taken    = pred_taken_reg;
    assign pred_target   = pred_target_reg;
    assign br_count      = br_count_reg;
    assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int IDXW = 6;
    localparam int TAGW = 8;
    localparam int N    = 64;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_br_en = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_br_en(upd_br_en),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .flush(flush),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers and arrays, counter as a clamped int.
    int          m_cnt [N];
    bit          m_val [N];
    int          m_tag [N];
    logic [31:0] m_tgt [N];
    longint      m_br, m_mis;
    bit          e_valid, e_taken;
    logic [31:0] e_target;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction
    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (IDXW + 2)) % (1 << TAGW));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = '0;
        end
        m_br = 0; m_mis = 0;
        e_valid = 0; e_taken = 0; e_target = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pred_valid"}, {31'd0, pred_valid}, {31'd0, e_valid});
        if (e_valid) begin
            check({tag, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, e_taken});
            check({tag, ".pred_target"}, pred_target, e_target);
        end
        check({tag, ".br_count"},      br_count,      m_br[31:0]);
        check({tag, ".mispred_count"}, mispred_count, m_mis[31:0]);
    endtask

    // One clock: drive inputs, model the edge, sample 1 time unit after it.
    task automatic cycle(input string tag,
                         input bit preq, input logic [31:0] ppc,
                         input bit uv, input logic [31:0] upc, input bit ubr,
                         input logic [31:0] utgt, input bit upt, input bit fl);
        int i;
        bit hit;
        pred_req = preq; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_br_en = ubr;
        upd_target = utgt; upd_pred_taken = upt; flush = fl;
        @(posedge clk);
        e_valid = preq;
        if (preq) begin
            i = idx_of(ppc);
            hit = m_val[i] && (m_tag[i] == tag_of(ppc));
            e_taken = hit && (m_cnt[i] >= 2);
            e_target = e_taken ? m_tgt[i] : ppc + 32'd4;
        end
        if (uv) begin
            i = idx_of(upc);
            m_cnt[i] = ubr ? ((m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1)
                           : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
            if (!fl && ubr) begin
                m_val[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt;
            end
            m_br  = (m_br + 1 > CMAX) ? CMAX : m_br + 1;
            if (ubr != upt) m_mis = (m_mis + 1 > CMAX) ? CMAX : m_mis + 1;
        end
        if (fl) for (int k = 0; k < N; k++) m_val[k] = 0;
        #1;
        check_all(tag);
        $display("txn %s: req=%0b pc=%h upd=%0b upc=%h br=%0b fl=%0b -> v=%0b t=%0b tgt=%h br=%0d mis=%0d",
                 tag, preq, ppc, uv, upc, ubr, fl, pred_valid, pred_taken, pred_target,
                 br_count, mispred_count);
    endtask

    task automatic pred(input string tag, input logic [31:0] pc);
        cycle(tag, 1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask
    task automatic upd(input string tag, input logic [31:0] pc, input bit br,
                       input logic [31:0] tgt, input bit pt);
        cycle(tag, 1'b0, 32'd0, 1'b1, pc, br, tgt, pt, 1'b0);
    endtask

    logic [31:0] pcs [4];

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1. first prediction after reset
        pred("t1", 32'h40);
        check("t1.taken_const", {31'd0, pred_taken}, 32'd0);
        check("t1.target_const", pred_target, 32'h44);

        // 2. train taken twice, predict; then three not-taken updates
        upd("t2.u1", 32'h40, 1'b1, 32'h100, 1'b0);
        upd("t2.u2", 32'h40, 1'b1, 32'h100, 1'b0);
        pred("t2.p1", 32'h40);
        check("t2.taken_const", {31'd0, pred_taken}, 32'd1);
        check("t2.target_const", pred_target, 32'h100);
        upd("t2.u3", 32'h40, 1'b0, 32'h0, 1'b1);
        upd("t2.u4", 32'h40, 1'b0, 32'h0, 1'b1);
        upd("t2.u5", 32'h40, 1'b0, 32'h0, 1'b1);
        pred("t2.p2", 32'h40);
        check("t2.nt_target_const", pred_target, 32'h44);

        // 3. aliasing: same index, different tag
        upd("t3.u", 32'h40, 1'b1, 32'h200, 1'b0);
        pred("t3.alias", 32'h40 + (32'd1 << (IDXW + 2)));
        check("t3.alias_const", {31'd0, pred_taken}, 32'd0);

        // 4. same-cycle predict and update, no bypass
        cycle("t4.same", 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 1'b0);
        check("t4.same_const", {31'd0, pred_taken}, 32'd0);
        pred("t4.after", 32'h40);
        check("t4.after_const", {31'd0, pred_taken}, 32'd1);

        // 5. flush with taken update at a new PC
        cycle("t5.flush", 1'b0, 32'd0, 1'b1, 32'h80, 1'b1, 32'h400, 1'b0, 1'b1);
        pred("t5.p40", 32'h40);
        pred("t5.p80", 32'h80);
        upd("t5.u80", 32'h80, 1'b1, 32'h400, 1'b0);
        pred("t5.p80b", 32'h80);
        check("t5.p80b_const", pred_target, 32'h400);

        // wrapping PC + 4
        pred("wrap", 32'hFFFF_FFFC);

        // randomized traffic over a few colliding PCs
        pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h140; pcs[3] = 32'h1080;
        for (int r = 0; r < 300; r++) begin
            logic [31:0] ppc, upc;
            ppc = ($urandom_range(0, 4) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
            upc = ($urandom_range(0, 4) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
            cycle("rand", 1'($urandom), ppc, 1'($urandom), upc, 1'($urandom),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom), ($urandom_range(0, 19) == 0));
        end

        // 6. saturation of the performance counters
        force dut.br_count_reg = 32'hFFFF_FFFF;
        force dut.mispred_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.br_count_reg;
        release dut.mispred_count_reg;
        m_br = CMAX; m_mis = CMAX;
        upd("t6.sat", 32'h40, 1'b1, 32'h100, 1'b0);
        check("t6.br_const", br_count, 32'hFFFF_FFFF);

        // async reset while a prediction is in flight
        @(negedge clk);
        pred_req = 1'b1; pred_pc = 32'h40; upd_valid = 1'b0; flush = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.reset");
        $display("txn t6.reset: v=%0b br=%0d mis=%0d", pred_valid, br_count, mispred_count);
        pred_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pred("t6.post", 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
